// File: rtl/fact_pkg.sv
// Shared state encoding for the factorial engine and its inverse, inv_factorial.
// The 3-bit codes double as the curr_state debug value.
package fact_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_CHECK = 3'd2,
        ST_MULT  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam int CYCLE_W = 8;

    // Saturating increment for the optional iteration counter.
    function automatic logic [CYCLE_W-1:0] sat_inc(input logic [CYCLE_W-1:0] x);
        return (x == {CYCLE_W{1'b1}}) ? x : x + 1'b1;
    endfunction

endpackage

// File: rtl/inv_fact_dp.sv
// Datapath for inv_factorial: target/acc/k registers, the running factorial
// product and the eq/gt compare against the captured target.
module inv_fact_dp #(
    parameter int SIZE = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            init,
    input  logic            step,
    input  logic [SIZE-1:0] value,
    output logic [SIZE-1:0] k,
    output logic            eq,
    output logic            gt
);

    localparam int AW = 2 * SIZE;

    logic [SIZE-1:0] target;
    logic [AW-1:0]   acc;
    logic [SIZE-1:0] k_next;
    logic [AW-1:0]   prod;

    // acc never exceeds target < 2^SIZE before a step, so AW bits hold the product.
    assign k_next = k + 1'b1;
    assign prod   = acc * AW'(k_next);
    assign eq     = (acc == AW'(target));
    assign gt     = (acc >  AW'(target));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            target <= '0;
            acc    <= AW'(1);
            k      <= SIZE'(1);
        end else begin
            if (load) begin
                target <= value;
            end
            if (init) begin
                acc <= AW'(1);
                k   <= SIZE'(1);
            end else if (step) begin
                acc <= prod;
                k   <= k_next;
            end
        end
    end

endmodule

// File: rtl/inv_factorial.sv
// Inverse factorial: reports n when value == n! (n >= 1), with a go/done handshake.
// Optional INV_FACT_CYCLE_COUNT_EN adds a saturating CHECK/MULT cycle counter port.
module inv_factorial
    import fact_pkg::*;
#(
    parameter int SIZE = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            go,
    input  logic [SIZE-1:0] value,
    output logic [2:0]      curr_state,
    output logic            done,
    output logic            valid,
`ifdef INV_FACT_CYCLE_COUNT_EN
    output logic [7:0]      cycles,
`endif
    output logic [SIZE-1:0] n
);

    state_t          state;
    logic [SIZE-1:0] k;
    logic            eq;
    logic            gt;
    logic            load;
    logic            init;
    logic            step;

    assign curr_state = state;
    assign load       = (state == ST_IDLE) && go;
    assign init       = (state == ST_LOAD);
    assign step       = (state == ST_MULT);

    inv_fact_dp #(.SIZE(SIZE)) u_dp (
        .clk   (clk),
        .rst   (rst),
        .load  (load),
        .init  (init),
        .step  (step),
        .value (value),
        .k     (k),
        .eq    (eq),
        .gt    (gt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            done  <= 1'b0;
            valid <= 1'b0;
            n     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (go) begin
                        state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    valid <= 1'b0;
                    n     <= '0;
                    state <= ST_CHECK;
                end
                ST_CHECK: begin
                    if (eq) begin
                        valid <= 1'b1;
                        n     <= k;
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end else if (gt) begin
                        valid <= 1'b0;
                        n     <= '0;
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end else begin
                        state <= ST_MULT;
                    end
                end
                ST_MULT: begin
                    state <= ST_CHECK;
                end
                ST_DONE: begin
                    // Holding go keeps the result on display; no auto-restart.
                    if (!go) begin
                        done  <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef INV_FACT_CYCLE_COUNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycles <= '0;
        end else if (state == ST_LOAD) begin
            cycles <= '0;
        end else if (state == ST_CHECK || state == ST_MULT) begin
            cycles <= sat_inc(cycles);
        end
    end
`endif

endmodule

// File: tb/tb_inv_factorial.sv
// Bench for inv_factorial: scoreboard fed by a factorial-table reference model,
// plus an async-reset abort on a SIZE=10 instance. Honours INV_FACT_CYCLE_COUNT_EN.
module tb_inv_factorial;

    localparam int SIZE = 8;

    logic            clk;
    logic            rst;
    logic            go;
    logic [SIZE-1:0] value;
    logic [2:0]      curr_state;
    logic            done;
    logic            valid;
    logic [SIZE-1:0] n;

    logic            go10;
    logic            rst10;
    logic [9:0]      value10;
    logic [2:0]      curr_state10;
    logic            done10;
    logic            valid10;
    logic [9:0]      n10;

`ifdef INV_FACT_CYCLE_COUNT_EN
    logic [7:0]      cycles;
    logic [7:0]      cycles10;
`endif

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Expected response queues, one entry per issued request.
    logic [SIZE-1:0] exp_q[$];
    logic            exp_valid_q[$];
    int              exp_lat_q[$];
    int              start_q[$];

    inv_factorial #(.SIZE(SIZE)) dut (
        .clk        (clk),
        .rst        (rst),
        .go         (go),
        .value      (value),
        .curr_state (curr_state),
        .done       (done),
        .valid      (valid),
`ifdef INV_FACT_CYCLE_COUNT_EN
        .cycles     (cycles),
`endif
        .n          (n)
    );

    inv_factorial #(.SIZE(10)) dut10 (
        .clk        (clk),
        .rst        (rst10),
        .go         (go10),
        .value      (value10),
        .curr_state (curr_state10),
        .done       (done10),
        .valid      (valid10),
`ifdef INV_FACT_CYCLE_COUNT_EN
        .cycles     (cycles10),
`endif
        .n          (n10)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference model: smallest k >= 1 with k! >= v; exact match means valid.
    task automatic model(input int v, output logic ok, output int nn, output int lat);
        int f;
        int k;
        f = 1;
        k = 1;
        while (f < v) begin
            k = k + 1;
            f = f * k;
        end
        ok  = (f == v);
        nn  = ok ? k : 0;
        lat = 2 * k + 1;
    endtask

    // Driver: issue one request at a negedge in IDLE, hold go until done.
    task automatic run_txn(input logic [SIZE-1:0] v, input int hold);
        logic ok;
        int   nn;
        int   lat;
        int   waited;
        logic [SIZE-1:0] n_seen;
        logic v_seen;
        model(int'(v), ok, nn, lat);
        exp_q.push_back(SIZE'(nn));
        exp_valid_q.push_back(ok);
        exp_lat_q.push_back(lat);
        start_q.push_back(cyc + 1);
        value = v;
        go    = 1'b1;
        @(negedge clk);
        value = SIZE'($urandom);
        waited = 0;
        while (!done && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (!done) begin
            check("done_timeout", 0, 1);
            void'(exp_q.pop_back());
            void'(exp_valid_q.pop_back());
            void'(exp_lat_q.pop_back());
            void'(start_q.pop_back());
        end
        n_seen = n;
        v_seen = valid;
        for (int i = 0; i < hold; i++) begin
            value = SIZE'($urandom);
            @(negedge clk);
            check("hold_state", curr_state, 4);
            check("hold_done", done, 1);
            check("hold_n", n, n_seen);
            check("hold_valid", valid, v_seen);
        end
        go = 1'b0;
        @(negedge clk);
        check("release_state", curr_state, 0);
        check("release_done", done, 0);
    endtask

    // Monitor: compare on each rising done against the head of the queues.
    logic prev_done = 1'b0;
    always @(negedge clk) begin
        if (done && !prev_done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                logic [SIZE-1:0] e_n;
                logic e_v;
                int e_lat;
                int s;
                e_n   = exp_q.pop_front();
                e_v   = exp_valid_q.pop_front();
                e_lat = exp_lat_q.pop_front();
                s     = start_q.pop_front();
                check("result_n", n, e_n);
                check("result_valid", valid, e_v);
                check("latency", cyc - s + 1, e_lat);
`ifdef INV_FACT_CYCLE_COUNT_EN
                check("cycles", cycles, (e_lat - 2 > 255) ? 255 : e_lat - 2);
`endif
            end
        end
        prev_done = done;
    end

    initial begin
        int fact_tab[6];
        int waited;
        fact_tab = '{1, 2, 6, 24, 120, 1};
        rst = 1'b1; go = 1'b0; value = '0;
        rst10 = 1'b1; go10 = 1'b0; value10 = '0;
        repeat (3) @(negedge clk);
        check("reset_state", curr_state, 0);
        check("reset_done", done, 0);
        check("reset_valid", valid, 0);
        check("reset_n", n, 0);
        rst = 1'b0;
        rst10 = 1'b0;
        @(negedge clk);

        run_txn(8'd120, 0);
        run_txn(8'd1, 0);
        run_txn(8'd0, 0);
        run_txn(8'd100, 0);
        run_txn(8'd255, 0);
        run_txn(8'd2, 0);
        run_txn(8'd6, 0);
        run_txn(8'd120, 6);
        run_txn(8'd24, 0);

        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 1) == 1)
                run_txn(SIZE'(fact_tab[$urandom_range(0, 4)]), $urandom_range(0, 2));
            else
                run_txn(SIZE'($urandom_range(0, 255)), $urandom_range(0, 2));
        end

        // Async reset mid-MULT on the SIZE=10 instance, then re-issue.
        value10 = 10'd720;
        go10    = 1'b1;
        waited  = 0;
        while (curr_state10 != 3'd3 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        go10 = 1'b0;
        repeat (4) @(negedge clk);
        while (curr_state10 != 3'd3 && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        check("abort_reached_mult", curr_state10, 3);
        #2 rst10 = 1'b1;
        #1;
        check("abort_state", curr_state10, 0);
        check("abort_done", done10, 0);
        check("abort_valid", valid10, 0);
        check("abort_n", n10, 0);
        @(negedge clk);
        rst10 = 1'b0;
        @(negedge clk);
        check("abort_no_pending", curr_state10, 0);
        go10 = 1'b1;
        waited = 0;
        while (!done10 && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        check("reissue_done", done10, 1);
        check("reissue_n", n10, 6);
        check("reissue_valid", valid10, 1);
        go10 = 1'b0;
        repeat (2) @(negedge clk);

        check("queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
